// File: rtl/cache_wb_burst_if.sv
// cache_wb_burst_if: CPU request port and burst PSRAM port of the write-back cache.
interface cache_wb_burst_if #(
    parameter int BURST_DATA_BITWIDTH = 64,
    parameter int BURST_RAM_DEPTH_BITWIDTH = 21
);
    logic [31:0] address;
    logic [31:0] data_out;
    logic data_out_ready;
    logic [31:0] data_in;
    logic [3:0] write_enable;
    logic busy;
    logic br_cmd;
    logic br_cmd_en;
    logic [BURST_RAM_DEPTH_BITWIDTH-1:0] br_addr;
    logic [BURST_DATA_BITWIDTH-1:0] br_wr_data;
    logic [BURST_DATA_BITWIDTH/8-1:0] br_data_mask;
    logic [BURST_DATA_BITWIDTH-1:0] br_rd_data;
    logic br_rd_data_valid;
    modport master (
        output address, data_in, write_enable, br_rd_data, br_rd_data_valid,
        input data_out, data_out_ready, busy, br_cmd, br_cmd_en, br_addr, br_wr_data, br_data_mask
    );
    modport slave (
        input address, data_in, write_enable, br_rd_data, br_rd_data_valid,
        output data_out, data_out_ready, busy, br_cmd, br_cmd_en, br_addr, br_wr_data, br_data_mask
    );
endinterface

// File: rtl/cache_wb_burst.sv
// cache_wb_burst: direct-mapped write-back cache in front of a burst PSRAM controller.
// Define CACHE_STATS_EN to add the stat_hits / stat_misses / stat_evictions counters.
module cache_wb_burst #(
    parameter int LINE_IX_BITWIDTH = 8,
    parameter int COLUMN_IX_BITWIDTH = 3,
    parameter int BURST_DATA_BITWIDTH = 64,
    parameter int BURST_RAM_DEPTH_BITWIDTH = 21,
    parameter int COMMAND_DELAY_INTERVAL = 13
) (
    input logic clk,
    input logic rst_n,
    cache_wb_burst_if.slave bus
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0] stat_hits,
    output logic [31:0] stat_misses,
    output logic [31:0] stat_evictions
`endif
);
    localparam int L = LINE_IX_BITWIDTH;
    localparam int C = COLUMN_IX_BITWIDTH;
    localparam int B = BURST_DATA_BITWIDTH;
    localparam int D = BURST_RAM_DEPTH_BITWIDTH;
    localparam int W = B / 32;
    localparam int WB = $clog2(W);
    localparam int BEATS = (2 ** C) / W;
    localparam int BB = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam int TAG_W = 30 - L - C;
    localparam int CW = COMMAND_DELAY_INTERVAL > 0 ? $clog2(COMMAND_DELAY_INTERVAL + 1) : 1;
    localparam logic [3:0] INIT = 4'd0, IDLE = 4'd1, EVICT = 4'd2, EVICT_WAIT = 4'd3,
        FILL_CMD = 4'd4, FILL_WAIT = 4'd5, FILL = 4'd6, TAG_UPDATE = 4'd7, FINISH = 4'd8;

    logic [TAG_W+1:0] tag_ram [2**L];
    // Data is stored one burst beat per entry so fills and evictions move whole beats.
    logic [B-1:0] data_ram [2**(L+BB)];
    logic [3:0] state;
    logic [CW-1:0] cnt;
    logic [BB-1:0] beat;
    logic [L-1:0] init_ix;
    logic br_cmd_r, br_cmd_en_r;
    logic [D-1:0] br_addr_r;
    logic [B-1:0] br_wr_data_r;
    logic [TAG_W-1:0] tag;
    logic [L-1:0] line_ix;
    logic [C-1:0] col;
    logic [TAG_W+1:0] entry;
    logic [L+BB-1:0] cpu_ix;
    logic [B-1:0] rd_beat, ev_data, wmask, wdata;
    logic [31:0] bmask;
    logic [29-C:0] req_line, ev_line;
    logic hit, wr_hit, miss, dirty, fill_we, go_fill;
    int sh;

    assign tag = bus.address[31 -: TAG_W];
    assign line_ix = bus.address[2+C +: L];
    assign col = bus.address[2 +: C];
    assign entry = tag_ram[line_ix];
    assign dirty = entry[TAG_W+1];
    assign req_line = {tag, line_ix};
    assign ev_line = {entry[TAG_W-1:0], line_ix};
    assign cpu_ix = {line_ix, BB'(col >> WB)};
    assign sh = 32 * (int'(col) % W);
    assign rd_beat = data_ram[cpu_ix];
    assign ev_data = data_ram[{line_ix, beat}];
    assign bmask = {{8{bus.write_enable[3]}}, {8{bus.write_enable[2]}}, {8{bus.write_enable[1]}}, {8{bus.write_enable[0]}}};
    assign wmask = B'(bmask) << sh;
    assign wdata = B'(bus.data_in) << sh;
    assign hit = state == IDLE && entry[TAG_W] && entry[TAG_W-1:0] == tag;
    assign wr_hit = hit && |bus.write_enable;
    assign miss = state == IDLE && !hit && cnt == 0;
    assign fill_we = (state == FILL_WAIT || state == FILL) && bus.br_rd_data_valid;
    assign go_fill = (miss && !dirty) || (state == EVICT_WAIT && cnt == 0);
    assign bus.busy = !hit || cnt != 0;
    assign bus.data_out = 32'(rd_beat >> sh);
    assign bus.data_out_ready = hit && bus.write_enable == 4'd0;
    assign bus.br_cmd = br_cmd_r;
    assign bus.br_cmd_en = br_cmd_en_r;
    assign bus.br_addr = br_addr_r;
    assign bus.br_wr_data = br_wr_data_r;
    assign bus.br_data_mask = '0;

    always_ff @(posedge clk) begin
        if (state == INIT) tag_ram[init_ix] <= '0;
        else if (state == TAG_UPDATE) tag_ram[line_ix] <= {2'b01, tag};
        else if (wr_hit) tag_ram[line_ix][TAG_W+1] <= 1'b1;
        if (fill_we) data_ram[{line_ix, beat}] <= bus.br_rd_data;
        else if (wr_hit) data_ram[cpu_ix] <= (rd_beat & ~wmask) | (wdata & wmask);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= INIT;
            cnt <= '0;
            beat <= '0;
            init_ix <= '0;
            br_cmd_r <= 1'b0;
            br_cmd_en_r <= 1'b0;
            br_addr_r <= '0;
            br_wr_data_r <= '0;
        end else begin
            br_cmd_en_r <= 1'b0;
            cnt <= cnt != 0 ? cnt - 1'b1 : cnt;
            case (state)
                INIT: begin
                    init_ix <= init_ix + 1'b1;
                    if (&init_ix) state <= IDLE;
                end
                IDLE: if (miss && dirty) begin
                    state <= BEATS > 1 ? EVICT : EVICT_WAIT;
                    br_cmd_r <= 1'b1;
                    br_cmd_en_r <= 1'b1;
                    br_addr_r <= D'(32'(ev_line) * BEATS);
                    br_wr_data_r <= ev_data;
                    beat <= BB'(BEATS > 1);
                    cnt <= CW'(COMMAND_DELAY_INTERVAL);
                end
                EVICT: begin
                    br_wr_data_r <= ev_data;
                    beat <= beat + 1'b1;
                    if (beat == BB'(BEATS - 1)) begin
                        beat <= '0;
                        state <= EVICT_WAIT;
                    end
                end
                FILL_CMD: state <= FILL_WAIT;
                FILL_WAIT, FILL: if (bus.br_rd_data_valid) begin
                    beat <= beat + 1'b1;
                    state <= FILL;
                    if (beat == BB'(BEATS - 1)) begin
                        beat <= '0;
                        state <= TAG_UPDATE;
                    end
                end
                TAG_UPDATE: state <= FINISH;
                FINISH: state <= IDLE;
                default: ;
            endcase
            if (go_fill) begin
                state <= FILL_CMD;
                br_cmd_r <= 1'b0;
                br_cmd_en_r <= 1'b1;
                br_addr_r <= D'(32'(req_line) * BEATS);
                beat <= '0;
                cnt <= CW'(COMMAND_DELAY_INTERVAL);
            end
        end
    end

`ifdef CACHE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_hits <= '0;
            stat_misses <= '0;
            stat_evictions <= '0;
        end else begin
            if (!bus.busy && stat_hits != '1) stat_hits <= stat_hits + 1'b1;
            if (miss && stat_misses != '1) stat_misses <= stat_misses + 1'b1;
            if (miss && dirty && stat_evictions != '1) stat_evictions <= stat_evictions + 1'b1;
        end
    end
`endif
endmodule

// File: doc/cache_wb_burst.md
Name: cache_wb_burst

Overview:
Parametrised direct-mapped write-back cache between the CPU data/instruction port and the burst PSRAM controller. It generalises line size, burst data width and command spacing. A dirty line is evicted on any miss, whether the miss is a read or a write, before the refill. After reset, a hardware sweep invalidates all tags.

Parameters:
LINE_IX_BITWIDTH, 8, log2 of cache line count.
COLUMN_IX_BITWIDTH, 3, log2 of 32-bit words per line.
BURST_DATA_BITWIDTH, 64, burst RAM data bus width. It must be 32, 64 or 128, and must not exceed the line size.
BURST_RAM_DEPTH_BITWIDTH, 21, burst RAM address width, in BURST_DATA_BITWIDTH-sized words.
COMMAND_DELAY_INTERVAL, 13, minimum clk cycles between br_cmd_en pulses, minus one.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
address  in  32  byte address; bits [1:0] are ignored
data_out  out  32  word at address
data_out_ready  out  1  read hit; data_out is valid
data_in  in  32  write data
write_enable  in  4  byte write mask; 0 means read
busy  out  1  request not yet serviced
br_cmd  out  1  0 = read, 1 = write
br_cmd_en  out  1  one-cycle command strobe
br_addr  out  BURST_RAM_DEPTH_BITWIDTH  burst start address
br_wr_data  out  BURST_DATA_BITWIDTH  write beat data
br_data_mask  out  BURST_DATA_BITWIDTH/8  always 0 (all bytes written)
br_rd_data  in  BURST_DATA_BITWIDTH  read beat data
br_rd_data_valid  in  1  read beat valid

Behaviour:
- Derived values:
  - BEATS = (2^COLUMN_IX_BITWIDTH * 32) / BURST_DATA_BITWIDTH.
  - TAG = 32 - LINE_IX_BITWIDTH - COLUMN_IX_BITWIDTH - 2.
  - Line RAM address = {tag, line_ix} * BEATS, truncated to BURST_RAM_DEPTH_BITWIDTH.
- Address split: |tag|line_ix|column_ix|00|.
- Tag RAM entry: {dirty, valid, tag}. Data is held in 2^COLUMN_IX_BITWIDTH byte-enabled RAM columns.
- hit = valid && tag match && state==IDLE.
- busy = !hit || delay_counter != 0 || state != IDLE.
- data_out_ready = hit && write_enable==0.
- Read hit: data_out is combinational from the column RAM output. Zero added latency.
- Write hit: the masked bytes of column_ix are written at the next clk edge, and dirty is set in the same edge. Requester may change address the following cycle.
- Miss in IDLE with delay_counter==0:
  - Dirty line: go to EVICT.
  - Clean line: go to FILL_CMD.
- State machine: INIT, IDLE, EVICT, EVICT_WAIT, FILL_CMD, FILL_WAIT, FILL, TAG_UPDATE, FINISH.
- INIT:
  - Entered on reset release.
  - Writes tag 0 to lines 0..LINE_COUNT-1, one line per cycle; busy=1 throughout.
  - Then goes to IDLE.
- EVICT:
  - Cycle 0: br_cmd=1, br_cmd_en=1, br_addr=cached line address, br_wr_data=beat 0, counter loaded with COMMAND_DELAY_INTERVAL.
  - Following BEATS-1 cycles: beats 1..BEATS-1 in order, br_cmd_en=0.
  - Beat k holds words k*W .. k*W+W-1, where W = BURST_DATA_BITWIDTH/32; lowest word is in the lowest bits.
- EVICT_WAIT: hold until the counter reaches 0, then go to FILL_CMD.
- FILL_CMD: br_cmd=0, br_cmd_en=1 for one cycle, br_addr=requested line address, counter reloaded.
- FILL_WAIT / FILL:
  - Each br_rd_data_valid beat writes W columns with a full byte mask.
  - br_rd_data_valid is consumed only in FILL_WAIT/FILL; stray pulses elsewhere are ignored.
  - Beats arrive consecutively. A gap in valid stalls the beat index and does not advance it.
- TAG_UPDATE: writes {0, 1, address tag}.
- FINISH: one settle cycle, then IDLE. The request then hits.
- The requester must hold address, data_in and write_enable stable while busy. A write miss completes as a write hit after refill.
- The delay counter decrements to 0 independently of state, and no command issues while it is nonzero.
- Reset values:
  - br_cmd=0, br_cmd_en=0, br_addr=0, br_wr_data=0, br_data_mask=0.
  - Counter=0, state=INIT.
  - busy=1 (combinational, because state != IDLE).
  - data_out_ready=0 (combinational, because hit=0).
- Reset mid-burst: outputs clear asynchronously. Any partially filled line is invalidated by INIT. Outstanding RAM beats are ignored.

Optional Feature:
- Macro CACHE_STATS_EN.
- When defined, adds outputs stat_hits, stat_misses and stat_evictions, each 32 bits.
  - stat_hits: increments once per cycle in which a request completes as a hit (read ready, or write committed).
  - stat_misses: increments once per miss detected in IDLE.
  - stat_evictions: increments on each EVICT entry.
  - All three saturate at 0xFFFFFFFF and are cleared by rst_n.
- When undefined, the ports and counters do not exist.

Test Plan:
All cases use default parameters (BEATS = 4).
1. Release rst_n -> busy=1 for at least 256 cycles (INIT), no br_cmd_en. Then read 0x40 -> one read command with br_addr=0x8. Feed beats 0x00000001_00000000, 0x3_2, 0x5_4, 0x7_6 -> data_out=0x0 at 0x40 and 0x7 at 0x5C, data_out_ready=1.
2. After test 1, write 0xDEADBEEF to 0x44 with write_enable=4'b0011 -> busy=0 that cycle. A following read of 0x44 returns 0x0000BEEF.
3. After test 2, read 0x2040 -> write command with br_addr=0x8 and beats 0x0000BEEF_00000000, 0x3_2, 0x5_4, 0x7_6. Then a read command with br_addr=0x408, issued at least 14 cycles after the write command strobe.
4. Clean line, read miss 0x4040 -> no write command; only a read command, with br_addr=0x808.
5. Assert rst_n during the 2nd FILL beat -> br_cmd_en=0 immediately. After INIT, reading the same address misses again and issues a read command.
6. With CACHE_STATS_EN defined, run tests 1–3 -> stat_misses=2, stat_evictions=1, stat_hits≥2.
